// File: rtl/ctrl_pipeline_pkg.sv
// Shared constants and the decoded control bundle for the E/M/W control pipeline.
package ctrl_pipeline_pkg;

  // Writeback source select carried in ctrl_t.wbsel.
  localparam logic [1:0] wbALU = 2'b00;
  localparam logic [1:0] wbMEM = 2'b01;
  localparam logic [1:0] wbJAL = 2'b10;

  // Execute operand-forward selects.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  // Decoded control bundle that travels with each instruction.
  typedef struct packed {
    logic       pcsel;
    logic       immsel;
    logic       regwren;
    logic       rs1sel;
    logic       rs2sel;
    logic       memren;
    logic       memwren;
    logic [1:0] wbsel;
    logic [3:0] alusel;
    reg_idx_t   rd;
    reg_idx_t   rs1;
    reg_idx_t   rs2;
  } ctrl_t;

  // A bubble carries no side effects: every field is zero.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // Loads are recognised by their writeback source, never by memren.
  function automatic logic is_load(input ctrl_t c);
    return (c.wbsel == wbMEM);
  endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_unit.sv
// Combinational hazard logic: load-use stall, branch flush and operand forwarding.
module hazard_unit
  import ctrl_pipeline_pkg::*;
(
  input  logic       d_valid,
  input  reg_idx_t   d_rs1,
  input  reg_idx_t   d_rs2,
  input  logic       e_valid,
  input  logic       e_regwren,
  input  logic       e_load,
  input  reg_idx_t   e_rd,
  input  reg_idx_t   e_rs1,
  input  reg_idx_t   e_rs2,
  input  logic       e_brtaken,
  input  logic       m_valid,
  input  logic       m_regwren,
  input  logic       m_load,
  input  reg_idx_t   m_rd,
  input  logic       w_valid,
  input  logic       w_regwren,
  input  reg_idx_t   w_rd,
  output logic       stall,
  output logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic load_use;
  logic m_can_fwd;
  logic w_can_fwd;

  // Load-use detection; a taken branch in E squashes D anyway, so flush wins.
  always_comb begin
    load_use = e_valid && e_regwren && e_load && (e_rd != '0) && d_valid &&
               ((d_rs1 == e_rd) || (d_rs2 == e_rd));
    flush    = e_brtaken && e_valid;
    stall    = load_use && !flush;
  end

  // Qualify each later stage as a forwarding source; a load in M has no data yet.
  always_comb begin
    m_can_fwd = m_valid && m_regwren && (m_rd != '0) && !m_load;
    w_can_fwd = w_valid && w_regwren && (w_rd != '0);
  end

  // Forward select for rs1: M is younger than W, so it takes priority.
  always_comb begin
    fwd_a = FWD_NONE;
    if (e_valid) begin
      if (m_can_fwd && (m_rd == e_rs1)) begin
        fwd_a = FWD_MEM;
      end else if (w_can_fwd && (w_rd == e_rs1)) begin
        fwd_a = FWD_WB;
      end
    end
  end

  // Forward select for rs2, same priority as rs1.
  always_comb begin
    fwd_b = FWD_NONE;
    if (e_valid) begin
      if (m_can_fwd && (m_rd == e_rs2)) begin
        fwd_b = FWD_MEM;
      end else if (w_can_fwd && (w_rd == e_rs2)) begin
        fwd_b = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline for E/M/W stages: stage registers, bubble insertion and
// stall/flush performance counters. Hazard decisions come from hazard_unit.
//
// Handshake: there is no valid/ready flow control here. d_valid_i qualifies
// d_ctrl_i every cycle; stall_o tells the front end to hold PC and F/D for the
// current cycle, flush_o tells it to discard F/D. Each stage's *_valid_o
// qualifies its *_ctrl_o.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid_i,
  input  ctrl_t       d_ctrl_i,
  input  logic        e_brtaken_i,
  output ctrl_t       e_ctrl_o,
  output ctrl_t       m_ctrl_o,
  output ctrl_t       w_ctrl_o,
  output logic        e_valid_o,
  output logic        m_valid_o,
  output logic        w_valid_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  // DWIDTH only keeps the parameter list aligned with the decode-stage modules.
  localparam logic [31:0] DWIDTH_VEC = 32'(DWIDTH);
  logic unused_dwidth;
  assign unused_dwidth = ^DWIDTH_VEC;

  ctrl_t       e_ctrl;
  ctrl_t       m_ctrl;
  ctrl_t       w_ctrl;
  logic        e_valid;
  logic        m_valid;
  logic        w_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic        stall;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        e_load;
  logic        m_load;
  logic        insert_bubble;

  // Classify the instructions in E and M as loads.
  always_comb begin
    e_load        = is_load(e_ctrl);
    m_load        = is_load(m_ctrl);
    insert_bubble = stall || flush;
  end

  hazard_unit u_hazard (
    .d_valid   (d_valid_i),
    .d_rs1     (d_ctrl_i.rs1),
    .d_rs2     (d_ctrl_i.rs2),
    .e_valid   (e_valid),
    .e_regwren (e_ctrl.regwren),
    .e_load    (e_load),
    .e_rd      (e_ctrl.rd),
    .e_rs1     (e_ctrl.rs1),
    .e_rs2     (e_ctrl.rs2),
    .e_brtaken (e_brtaken_i),
    .m_valid   (m_valid),
    .m_regwren (m_ctrl.regwren),
    .m_load    (m_load),
    .m_rd      (m_ctrl.rd),
    .w_valid   (w_valid),
    .w_regwren (w_ctrl.regwren),
    .w_rd      (w_ctrl.rd),
    .stall     (stall),
    .flush     (flush),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  // Stage shift: E takes D or a bubble, M and W always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      m_valid <= 1'b0;
      w_valid <= 1'b0;
      e_ctrl  <= CTRL_BUBBLE;
      m_ctrl  <= CTRL_BUBBLE;
      w_ctrl  <= CTRL_BUBBLE;
    end else begin
      if (insert_bubble) begin
        e_valid <= 1'b0;
        e_ctrl  <= CTRL_BUBBLE;
      end else begin
        e_valid <= d_valid_i;
        e_ctrl  <= d_ctrl_i;
      end
      m_valid <= e_valid;
      m_ctrl  <= e_ctrl;
      w_valid <= m_valid;
      w_ctrl  <= m_ctrl;
    end
  end

  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  // Drive the outputs from the registered state and hazard decisions.
  always_comb begin
    e_ctrl_o    = e_ctrl;
    m_ctrl_o    = m_ctrl;
    w_ctrl_o    = w_ctrl;
    e_valid_o   = e_valid;
    m_valid_o   = m_valid;
    w_valid_o   = w_valid;
    stall_o     = stall;
    flush_o     = flush;
    fwd_a_o     = fwd_a;
    fwd_b_o     = fwd_b;
    stall_cnt_o = stall_cnt;
    flush_cnt_o = flush_cnt;
  end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL take parameter DWIDTH, default 32, datapath width, used only for lint consistency with the decode-stage modules.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port d_valid_i, input, 1 bit: decode stage holds a real instruction.
REQ-006 SHALL have port d_ctrl_i, input, ctrl_t: decoded control bundle from the decode stage.
REQ-007 SHALL have port e_brtaken_i, input, 1 bit: branch or jump in execute resolved taken this cycle.
REQ-008 SHALL have ports e_ctrl_o, m_ctrl_o and w_ctrl_o, output, ctrl_t each: registered control for the execute, memory and writeback stages.
REQ-009 SHALL have ports e_valid_o, m_valid_o and w_valid_o, output, 1 bit each: the stage holds a real instruction.
REQ-010 SHALL have port stall_o, output, 1 bit: freeze PC and the F/D register this cycle.
REQ-011 SHALL have port flush_o, output, 1 bit: discard the F/D contents this cycle.
REQ-012 SHALL have ports fwd_a_o and fwd_b_o, output, 2 bits each: execute operand-forward select for rs1 and rs2.
REQ-013 SHALL have ports stall_cnt_o and flush_cnt_o, output, 32 bits each: performance counters.

Function
REQ-014 ctrl_t fields SHALL be: pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren, wbsel[1:0], alusel[3:0], rd[4:0], rs1[4:0], rs2[4:0].
REQ-015 With no stall and no flush, each rising clk SHALL shift the stages: E<=D, M<=E, W<=M, with valid bits following their control bundles.
REQ-016 A load SHALL be identified by wbsel==wbMEM; memren SHALL NOT be used to identify loads.
REQ-017 stall_o SHALL be combinational and assert when all of the following hold:
- e_valid, e.regwren and e is a load
- e.rd!=0 and d_valid_i
- d.rs1==e.rd or d.rs2==e.rd
REQ-018 On a stall, E SHALL load a bubble next cycle, M<=E and W<=M SHALL still advance, and the stall SHALL last exactly 1 cycle.
REQ-019 flush_o SHALL equal e_brtaken_i & e_valid; on a flush, E SHALL load a bubble next cycle, M<=E and W<=M SHALL advance.
REQ-020 When a stall and a flush occur together, the flush SHALL win: stall_o=0, and stall_cnt_o SHALL NOT increment.
REQ-021 A bubble SHALL have valid=0 and all ctrl_t fields zero, so regwren=0 and memwren=0.
REQ-022 fwd_a_o SHALL select the forward source for e.rs1, with priority:
- 01 (from M) if m_valid, m.regwren, m.rd!=0, m.rd==e.rs1 and M is not a load
- else 10 (from W) if w_valid, w.regwren, w.rd!=0 and w.rd==e.rs1
- else 00
REQ-023 fwd_b_o SHALL follow the same rule as fwd_a_o using e.rs2.
REQ-024 rd==0 SHALL never cause a stall or a forward.
REQ-025 When E is invalid, fwd_a_o and fwd_b_o SHALL be 00.
REQ-026 stall_cnt_o SHALL increment by 1 on each cycle with stall_o=1; flush_cnt_o SHALL increment by 1 on each cycle with flush_o=1.
REQ-027 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 Latency from D to each stage output SHALL be 1, 2 and 3 cycles respectively, plus 1 per stall bubble.

Reset
REQ-029 When reset=1 at a clk edge, all valid bits SHALL become 0, all ctrl_t outputs 0, and both counters 0.
REQ-030 After reset, stall_o, flush_o, fwd_a_o and fwd_b_o SHALL be 0.
REQ-031 Reset SHALL take priority over stall, flush and counter increments, including mid-operation.

Structure
REQ-032 ctrl_t and the forward-select encodings FWD_NONE=00, FWD_MEM=01 and FWD_WB=10 SHALL live in the shared constants package beside wbMEM/wbALU/wbJAL.
REQ-033 Stall and forward logic SHALL be one combinational sub-module, hazard_unit; stage registers and counters SHALL stay in ctrl_pipeline.

Verification
REQ-034 Load-use: lw x5 in E, d={rs1=5} with d_valid=1 -> stall_o=1 for 1 cycle; the next cycle e_valid_o=0 and stall_cnt_o=1.
REQ-035 Forward priority: add x3 in M and addi x3 in W, E rs1=3 -> fwd_a_o=01; the same with M a load -> fwd_a_o=10.
REQ-036 x0: M writes rd=0 and E rs1=0 and rs2=0 -> fwd_a_o=fwd_b_o=00 and stall_o=0.
REQ-037 Flush vs stall: e_brtaken_i=1 while a load-use condition holds -> flush_o=1, stall_o=0; the next cycle e_valid_o=0, flush_cnt_o=1 and stall_cnt_o unchanged.
REQ-038 Mid-run reset: pipeline full with stall_cnt_o=7, reset=1 for one edge -> all valid outputs 0, all ctrl outputs 0, both counters 0.
REQ-039 Counter wrap: preload or force flush_cnt_o=0xFFFFFFFF, then one flush -> flush_cnt_o=0.
